// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: decodes RV immediates at acceptance and
// buffers results in a main register plus one skid entry behind a registered in_ready.
module imm_decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ZIMM_CSR = 1,
  parameter int unsigned TAG_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_Z = 3'd6;

  typedef struct packed {
    logic [31:0]      inst;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
  } entry_t;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
  entry_t          dec_c;

  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
  assign imm_z = XLEN'(in_inst[19:15]);

  // Opcode classification; every listed opcode already implies inst[1:0] == 2'b11
  always_comb begin
    dec_c.inst    = in_inst;
    dec_c.tag     = in_tag;
    dec_c.imm     = '0;
    dec_c.fmt     = FMT_R;
    dec_c.illegal = 1'b0;
    case (in_inst[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F: begin dec_c.fmt = FMT_I; dec_c.imm = imm_i; end
      7'h73: begin
        if ((ZIMM_CSR != 0) && in_inst[14]) begin
          dec_c.fmt = FMT_Z; dec_c.imm = imm_z;
        end else begin
          dec_c.fmt = FMT_I; dec_c.imm = imm_i;
        end
      end
      7'h23:        begin dec_c.fmt = FMT_S; dec_c.imm = imm_s; end
      7'h63:        begin dec_c.fmt = FMT_B; dec_c.imm = imm_b; end
      7'h17, 7'h37: begin dec_c.fmt = FMT_U; dec_c.imm = imm_u; end
      7'h6F:        begin dec_c.fmt = FMT_J; dec_c.imm = imm_j; end
      7'h33:        dec_c.fmt = FMT_R;
      7'h1B: begin
        if (XLEN == 64) begin dec_c.fmt = FMT_I; dec_c.imm = imm_i; end
        else dec_c.illegal = 1'b1;
      end
      7'h3B:   dec_c.illegal = (XLEN != 64);
      default: dec_c.illegal = 1'b1;
    endcase
  end

  entry_t main_q, main_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept, main_free;

  assign accept    = in_valid & in_ready_q;
  assign main_free = ~out_valid_q | out_ready;

  // Skid is only ever valid while main is full, so accept and skid refill never coincide
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) main_d = dec_c;
      end
    end else if (accept) begin
      skid_d       = dec_c;
      skid_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_inst    = main_q.inst;
  assign out_tag     = main_q.tag;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: a 32-bit/zimm and a 64-bit/no-zimm instance share stimulus
// and are checked each cycle against a FIFO-occupancy model with an arithmetic decoder.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_tag;

  logic        r32, v32, ill32, r64, v64, ill64;
  logic [31:0] inst32, tag32, imm32, inst64, tag64;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .ZIMM_CSR(1), .TAG_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(v32), .out_ready(out_ready),
    .out_inst(inst32), .out_tag(tag32), .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32));

  imm_decode_stage #(.XLEN(64), .ZIMM_CSR(0), .TAG_W(32)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(v64), .out_ready(out_ready),
    .out_inst(inst64), .out_tag(tag64), .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64));

  typedef struct packed { logic [63:0] imm; logic [2:0] fmt; logic ill; } dec_t;
  typedef struct packed { logic [31:0] inst; logic [31:0] tag; dec_t d32; dec_t d64; } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference decode written from the immediate bit layouts with signed arithmetic
  function automatic dec_t ref_dec(logic [31:0] i, bit x64, bit zimm);
    dec_t   r;
    longint v;
    int     kind;
    r.ill = 1'b0; v = 0; kind = 0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F: kind = 1;
      7'h73:        kind = (zimm && i[14]) ? 6 : 1;
      7'h23:        kind = 2;
      7'h63:        kind = 3;
      7'h17, 7'h37: kind = 4;
      7'h6F:        kind = 5;
      7'h33:        kind = 0;
      7'h1B:        if (x64) kind = 1; else r.ill = 1'b1;
      7'h3B:        if (!x64) r.ill = 1'b1;
      default:      r.ill = 1'b1;
    endcase
    case (kind)
      1: begin v = longint'(i[31:20]); if (v >= 2048) v -= 4096; end
      2: begin v = longint'({i[31:25], i[11:7]}); if (v >= 2048) v -= 4096; end
      3: begin v = longint'({i[31], i[7], i[30:25], i[11:8], 1'b0}); if (v >= 4096) v -= 8192; end
      4: begin v = longint'(i[31:12]) * 4096; if (i[31]) v -= 64'sd4294967296; end
      5: begin v = longint'({i[31], i[19:12], i[20], i[30:21], 1'b0}); if (v >= 1048576) v -= 2097152; end
      6: v = longint'(i[19:15]);
      default: v = 0;
    endcase
    r.fmt = 3'(kind);
    r.imm = x64 ? 64'(v) : {32'h0, v[31:0]};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic check_all();
    exp_t e;
    bit   ev, er;
    ev = (q.size() > 0);
    er = (q.size() < 2);
    chk("out_valid32", 64'(v32), 64'(ev));
    chk("out_valid64", 64'(v64), 64'(ev));
    chk("in_ready32",  64'(r32), 64'(er));
    chk("in_ready64",  64'(r64), 64'(er));
    if (ev) begin
      e = q[0];
      chk("out_inst32", 64'(inst32), 64'(e.inst));
      chk("out_tag32",  64'(tag32),  64'(e.tag));
      chk("out_imm32",  64'(imm32),  e.d32.imm);
      chk("out_fmt32",  64'(fmt32),  64'(e.d32.fmt));
      chk("out_ill32",  64'(ill32),  64'(e.d32.ill));
      chk("out_tag64",  64'(tag64),  64'(e.tag));
      chk("out_imm64",  imm64,       e.d64.imm);
      chk("out_fmt64",  64'(fmt64),  64'(e.d64.fmt));
      chk("out_ill64",  64'(ill64),  64'(e.d64.ill));
    end
  endtask

  // Drive one cycle of inputs, advance the occupancy model at the edge, then check
  task automatic do_cycle(input bit v, input logic [31:0] i, input logic [31:0] t,
                          input bit r, input bit f);
    bit   acc, drn;
    exp_t e;
    in_valid = v; in_inst = i; in_tag = t; out_ready = r; flush = f;
    acc = v && (q.size() < 2);
    drn = (q.size() > 0) && r;
    @(posedge clk);
    if (f) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        e.inst = i; e.tag = t;
        e.d32 = ref_dec(i, 1'b0, 1'b1);
        e.d64 = ref_dec(i, 1'b1, 1'b0);
        q.push_back(e);
      end
    end
    #1;
    check_all();
  endtask

  task automatic reset_checks();
    chk("rst_valid",  64'(v32 | v64),   64'(0));
    chk("rst_ready",  64'(r32 & r64),   64'(1));
    chk("rst_imm",    64'(imm32) | imm64, 64'(0));
    chk("rst_fmt",    64'(fmt32 | fmt64), 64'(0));
    chk("rst_ill",    64'(ill32 | ill64), 64'(0));
    chk("rst_inst",   64'(inst32 | inst64), 64'(0));
    chk("rst_tag",    64'(tag32 | tag64), 64'(0));
  endtask

  logic [6:0]  opcs [15];
  logic [31:0] rnd;

  initial begin
    opcs = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h17,
             7'h37, 7'h6F, 7'h33, 7'h1B, 7'h3B, 7'h7F, 7'h0B};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_tag = '0;
    #12;
    reset_checks();
    rst = 1'b0;
    @(posedge clk); #1;

    do_cycle(1, 32'hFFF00093, 32'h100, 1, 0);
    chk("addi_valid", 64'(v32), 64'(1));
    chk("addi_imm",   64'(imm32), 64'hFFFFFFFF);
    chk("addi_fmt",   64'(fmt32), 64'(1));
    chk("addi_ill",   64'(ill32), 64'(0));
    do_cycle(1, 32'hFE112E23, 32'h104, 1, 0);
    chk("sw_imm",  64'(imm32), 64'hFFFFFFFC); chk("sw_fmt",  64'(fmt32), 64'(2));
    do_cycle(1, 32'hFE000CE3, 32'h108, 1, 0);
    chk("beq_imm", 64'(imm32), 64'hFFFFFFF8); chk("beq_fmt", 64'(fmt32), 64'(3));
    do_cycle(1, 32'hFFDFF06F, 32'h10C, 1, 0);
    chk("jal_imm", 64'(imm32), 64'hFFFFFFFC); chk("jal_fmt", 64'(fmt32), 64'(5));
    do_cycle(1, 32'h3402D073, 32'h110, 1, 0);
    chk("zimm_imm", 64'(imm32), 64'd5);     chk("zimm_fmt", 64'(fmt32), 64'(6));
    chk("csri_imm", imm64, 64'h340);        chk("csri_fmt", 64'(fmt64), 64'(1));
    do_cycle(1, 32'h0000007F, 32'h114, 1, 0);
    chk("ill_flag", 64'(ill32), 64'(1));    chk("ill_imm", 64'(imm32), 64'(0));
    do_cycle(1, 32'h80000537, 32'h118, 1, 0);
    chk("lui64_imm", imm64, 64'hFFFFFFFF80000000); chk("lui64_fmt", 64'(fmt64), 64'(4));
    do_cycle(1, 32'h0000003B, 32'h11C, 1, 0);
    chk("op32_fmt64", 64'(fmt64), 64'(0));  chk("op32_ill64", 64'(ill64), 64'(0));
    chk("op32_ill32", 64'(ill32), 64'(1));
    do_cycle(0, 32'h0, 32'h0, 1, 0);

    // Back-pressure: two fill main+skid, third waits until skid frees
    do_cycle(1, 32'h00100093, 32'hA0, 0, 0);
    do_cycle(1, 32'h00200093, 32'hA1, 0, 0);
    chk("bp_ready_low", 64'(r32), 64'(0));
    do_cycle(1, 32'h00300093, 32'hA2, 0, 0);
    chk("bp_hold_tag", 64'(tag32), 64'hA0);
    do_cycle(1, 32'h00300093, 32'hA2, 1, 0);
    chk("bp_tag2", 64'(tag32), 64'hA1);
    do_cycle(1, 32'h00300093, 32'hA2, 1, 0);
    chk("bp_tag3", 64'(tag32), 64'hA2);
    do_cycle(0, 32'h0, 32'h0, 1, 0);

    // Flush with full buffer and a concurrent input
    do_cycle(1, 32'h00500093, 32'hB0, 0, 0);
    do_cycle(1, 32'h00600093, 32'hB1, 0, 0);
    do_cycle(1, 32'h00700093, 32'hB2, 0, 1);
    chk("flush_valid", 64'(v32), 64'(0));
    chk("flush_ready", 64'(r32), 64'(1));
    do_cycle(0, 32'h0, 32'h0, 1, 0);
    chk("flush_gone", 64'(v32), 64'(0));

    // Async reset mid-stream
    do_cycle(1, 32'h00800093, 32'hC0, 0, 0);
    do_cycle(1, 32'h00900093, 32'hC1, 0, 0);
    rst = 1'b1;
    #2;
    reset_checks();
    q.delete();
    rst = 1'b0;
    #1;

    for (int k = 0; k < 400; k++) begin
      rnd = $urandom;
      if ($urandom_range(0, 3) != 0) rnd[6:0] = opcs[$urandom_range(0, 14)];
      do_cycle(($urandom_range(0, 3) != 0), rnd, $urandom,
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
